rvc_inst_aligner: RTL and testbench

- Sits between instruction fetch and the decode stage (decode_com / 32-bit decoder).
- Accepts 32-bit aligned fetch words and buffers them as 16-bit halfwords.
- Extracts one instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary.
- Tracks the PC of each extracted instruction and supports a redirect (flush) to any halfword-aligned PC.

---
 rtl/rvc_inst_aligner_if.sv | 24 ++
 rtl/rvc_inst_aligner.sv | 97 +++++++++
 tb/tb_rvc_inst_aligner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rvc_inst_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the RVC instruction aligner.
// The aligner connects through the slave modport; fetch/decode stimulus uses master.
interface rvc_inst_aligner_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] fetch_data_i;
    logic        fetch_val_i;
    logic        fetch_rdy_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_com_o;
    logic        inst_val_o;
    logic        inst_rdy_i;

    modport slave (
        input  flush_i, flush_pc_i, fetch_data_i, fetch_val_i, inst_rdy_i,
        output fetch_rdy_o, inst_o, inst_pc_o, inst_com_o, inst_val_o
    );

    modport master (
        output flush_i, flush_pc_i, fetch_data_i, fetch_val_i, inst_rdy_i,
        input  fetch_rdy_o, inst_o, inst_pc_o, inst_com_o, inst_val_o
    );
endinterface

// File: rtl/rvc_inst_aligner.sv
// Halfword realigner between fetch and decode: buffers 32-bit fetch words and
// extracts one 16-bit compressed or 32-bit instruction per handshake, tracking its PC.
module rvc_inst_aligner #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rvc_inst_aligner_if.slave bus
);
    localparam int unsigned    PW       = $clog2(BUF_HW);
    localparam int unsigned    CW       = PW + 1;
    localparam logic [CW-1:0]  FILL_LIM = CW'(BUF_HW - 2);

    logic [15:0]   r_buf [BUF_HW];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc;
    logic          r_skip_lo;

    logic [PW-1:0] w_head_p1;
    logic [PW-1:0] w_tail_p1;
    logic [15:0]   w_h0;
    logic [15:0]   w_h1;
    logic          w_com;
    logic          w_val;
    logic          w_rdy;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;

    assign w_head_p1 = r_head + PW'(1);
    assign w_tail_p1 = r_tail + PW'(1);
    assign w_h0      = r_buf[r_head];
    assign w_h1      = r_buf[w_head_p1];
    assign w_com     = (w_h0[1:0] != 2'b11);
    assign w_val     = w_com ? (r_count >= CW'(1)) : (r_count >= CW'(2));

    // Ready looks only at the registered fill level, never at a same-cycle pop.
    assign w_rdy     = (r_count <= FILL_LIM) & ~bus.flush_i;
    assign w_push    = bus.fetch_val_i & w_rdy;
    assign w_pop     = w_val & bus.inst_rdy_i;
    assign w_push_n  = !w_push ? '0 : (r_skip_lo ? CW'(1) : CW'(2));
    assign w_pop_n   = !w_pop  ? '0 : (w_com     ? CW'(1) : CW'(2));

    assign bus.fetch_rdy_o = w_rdy;
    assign bus.inst_val_o  = w_val;
    assign bus.inst_com_o  = w_val & w_com;
    assign bus.inst_pc_o   = r_pc;

    always_comb begin
        bus.inst_o = '0;
        if (w_val) begin
            bus.inst_o = w_com ? {16'h0000, w_h0} : {w_h1, w_h0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pc      <= RESET_PC;
            r_skip_lo <= RESET_PC[1];
        end else if (bus.flush_i) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pc      <= bus.flush_pc_i;
            r_skip_lo <= bus.flush_pc_i[1];
        end else begin
            if (w_push) begin
                r_tail    <= r_skip_lo ? w_tail_p1 : (r_tail + PW'(2));
                r_skip_lo <= 1'b0;
            end
            if (w_pop) begin
                r_head <= w_com ? w_head_p1 : (r_head + PW'(2));
                r_pc   <= r_pc + (w_com ? 32'd2 : 32'd4);
            end
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            if (r_skip_lo) begin
                r_buf[r_tail] <= bus.fetch_data_i[31:16];
            end else begin
                r_buf[r_tail]    <= bus.fetch_data_i[15:0];
                r_buf[w_tail_p1] <= bus.fetch_data_i[31:16];
            end
        end
    end
endmodule

// File: tb/tb_rvc_inst_aligner.sv
// Directed bench for rvc_inst_aligner: hand-computed vectors plus a halfword-queue
// model for the pointer-wrap stream.
module tb_rvc_inst_aligner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rvc_inst_aligner_if bus_if ();

    rvc_inst_aligner #(
        .BUF_HW   (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic val, input logic [31:0] inst,
                             input logic com, input logic [31:0] pc);
        check_eq({tag, "_val"},  32'(bus_if.inst_val_o), 32'(val));
        check_eq({tag, "_inst"}, bus_if.inst_o, inst);
        check_eq({tag, "_com"},  32'(bus_if.inst_com_o), 32'(com));
        check_eq({tag, "_pc"},   bus_if.inst_pc_o, pc);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [31:0] data);
        bus_if.fetch_val_i  = 1'b1;
        bus_if.fetch_data_i = data;
        step();
        bus_if.fetch_val_i  = 1'b0;
    endtask

    logic [15:0] hw_tab [20] = '{16'h4001, 16'h0513, 16'h0001, 16'h4005, 16'h4009,
                                 16'h1113, 16'h2222, 16'h3333, 16'h0513, 16'h00AA,
                                 16'h400D, 16'h4011, 16'h4015, 16'h0593, 16'h7777,
                                 16'h4019, 16'h401D, 16'h4021, 16'h0613, 16'h0099};
    logic [15:0] q [$];
    logic [31:0] mpc;
    logic [31:0] exp_inst;
    logic        exp_com, exp_val, exp_rdy;
    int unsigned sent;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.flush_i      = 1'b0;
        bus_if.flush_pc_i   = '0;
        bus_if.fetch_data_i = '0;
        bus_if.fetch_val_i  = 1'b0;
        bus_if.inst_rdy_i   = 1'b1;
        #12 rst = 1'b0;
        step();

        // 1: reset state, then two compressed instructions from one word
        check_out("rst", 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("rst_frdy", 32'(bus_if.fetch_rdy_o), 32'd1);
        push(32'h0001_4501);
        check_out("t1a", 1'b1, 32'h0000_4501, 1'b1, 32'h0);
        step();
        check_out("t1b", 1'b1, 32'h0000_0001, 1'b1, 32'h2);
        step();
        check_out("t1c", 1'b0, 32'h0, 1'b0, 32'h4);

        // 2: 32-bit instruction straddling a fetch word
        do_reset();
        push(32'h0513_0001);
        check_out("t2a", 1'b1, 32'h0000_0001, 1'b1, 32'h0);
        step();
        check_out("t2wait", 1'b0, 32'h0, 1'b0, 32'h2);
        step();
        check_eq("t2wait2_val", 32'(bus_if.inst_val_o), 32'd0);
        push(32'h0001_0050);
        check_out("t2b", 1'b1, 32'h0050_0513, 1'b0, 32'h2);
        step();
        check_out("t2c", 1'b1, 32'h0000_0001, 1'b1, 32'h6);
        step();
        check_eq("t2d_val", 32'(bus_if.inst_val_o), 32'd0);

        // 3: flush to odd halfword; data offered during flush is dropped
        bus_if.flush_i      = 1'b1;
        bus_if.flush_pc_i   = 32'h0000_0102;
        bus_if.fetch_val_i  = 1'b1;
        bus_if.fetch_data_i = 32'hDEAD_BEEF;
        #1;
        check_eq("t3_frdy_flush", 32'(bus_if.fetch_rdy_o), 32'd0);
        step();
        bus_if.flush_i     = 1'b0;
        bus_if.fetch_val_i = 1'b0;
        check_out("t3post", 1'b0, 32'h0, 1'b0, 32'h102);
        push(32'h0001_4501);
        check_out("t3a", 1'b1, 32'h0000_0001, 1'b1, 32'h102);
        step();
        check_out("t3b", 1'b0, 32'h0, 1'b0, 32'h104);

        // 4: backpressure fills the buffer, then drains
        do_reset();
        bus_if.inst_rdy_i = 1'b0;
        push(32'h4505_4501);
        check_eq("t4_frdy2", 32'(bus_if.fetch_rdy_o), 32'd1);
        push(32'h450D_4509);
        check_eq("t4_frdy4", 32'(bus_if.fetch_rdy_o), 32'd0);
        check_out("t4full", 1'b1, 32'h0000_4501, 1'b1, 32'h0);
        push(32'hFFFF_FFFF);
        check_out("t4hold", 1'b1, 32'h0000_4501, 1'b1, 32'h0);
        bus_if.inst_rdy_i = 1'b1;
        step();
        check_out("t4p1", 1'b1, 32'h0000_4505, 1'b1, 32'h2);
        check_eq("t4_frdy3", 32'(bus_if.fetch_rdy_o), 32'd0);
        step();
        check_out("t4p2", 1'b1, 32'h0000_4509, 1'b1, 32'h4);
        check_eq("t4_frdy_back", 32'(bus_if.fetch_rdy_o), 32'd1);
        step();
        check_out("t4p3", 1'b1, 32'h0000_450D, 1'b1, 32'h6);
        step();
        check_eq("t4empty_val", 32'(bus_if.inst_val_o), 32'd0);

        // 5: simultaneous push and compressed pop at count 2
        do_reset();
        bus_if.inst_rdy_i = 1'b0;
        push(32'h4505_4501);
        bus_if.inst_rdy_i = 1'b1;
        push(32'h4511_450D);
        check_out("t5a", 1'b1, 32'h0000_4505, 1'b1, 32'h2);
        check_eq("t5_frdy3", 32'(bus_if.fetch_rdy_o), 32'd0);
        step();
        check_out("t5b", 1'b1, 32'h0000_450D, 1'b1, 32'h4);
        step();
        check_out("t5c", 1'b1, 32'h0000_4511, 1'b1, 32'h6);
        step();
        check_eq("t5d_val", 32'(bus_if.inst_val_o), 32'd0);

        // 5b: ten-word stream against a halfword queue model
        do_reset();
        q.delete();
        mpc  = 32'h0;
        sent = 0;
        for (int cyc = 0; cyc < 200 && (sent < 10 || q.size() > 0); cyc++) begin
            exp_rdy = (q.size() <= 2);
            check_eq("wrap_frdy", 32'(bus_if.fetch_rdy_o), 32'(exp_rdy));
            exp_com = (q.size() > 0) && (q[0][1:0] != 2'b11);
            exp_val = exp_com || (q.size() >= 2);
            check_eq("wrap_val", 32'(bus_if.inst_val_o), 32'(exp_val));
            if (exp_val) begin
                exp_inst = exp_com ? {16'h0000, q[0]} : {q[1], q[0]};
                check_eq("wrap_inst", bus_if.inst_o, exp_inst);
                check_eq("wrap_pc", bus_if.inst_pc_o, mpc);
                void'(q.pop_front());
                if (!exp_com) void'(q.pop_front());
                mpc = mpc + (exp_com ? 32'd2 : 32'd4);
            end
            bus_if.fetch_val_i = (sent < 10);
            if (sent < 10) begin
                bus_if.fetch_data_i = {hw_tab[2*sent+1], hw_tab[2*sent]};
                if (exp_rdy) begin
                    q.push_back(hw_tab[2*sent]);
                    q.push_back(hw_tab[2*sent+1]);
                    sent++;
                end
            end
            step();
        end
        bus_if.fetch_val_i = 1'b0;
        check_eq("wrap_sent", sent, 32'd10);
        check_eq("wrap_drained", q.size(), 32'd0);

        // 6: asynchronous reset mid-stream
        bus_if.flush_i    = 1'b1;
        bus_if.flush_pc_i = 32'h0000_0040;
        bus_if.inst_rdy_i = 1'b0;
        step();
        bus_if.flush_i = 1'b0;
        push(32'h4505_4501);
        bus_if.inst_rdy_i = 1'b1;
        push(32'h450D_4509);
        bus_if.inst_rdy_i = 1'b0;
        check_out("t6pre", 1'b1, 32'h0000_4505, 1'b1, 32'h42);
        #3 rst = 1'b1;
        #1;
        check_out("t6rst", 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("t6_frdy", 32'(bus_if.fetch_rdy_o), 32'd1);
        #2 rst = 1'b0;
        step();
        check_out("t6post", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
